// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS pipeline.
// Holds the fetch state encoding, the NOP encoding and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'd0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port and
// presents each fetched word (or a NOP bubble) to the IF/ID register.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus_4_out,
  output logic        fetch_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  pc_inc;
  logic [31:0]  redirect_aligned;

  assign pc_inc           = pc_q + 32'd4;
  assign redirect_aligned = word_align(redirect_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            pc_d = redirect_aligned;
          end else begin
            // Address must stay stable until the outstanding access is acked.
            target_d = redirect_aligned;
            state_d  = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_valid = 1'b1;
          if (pc_write) begin
            pc_d = pc_inc;
          end
        end
      end

      DISCARD: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_d    = redirect ? redirect_aligned : target_q;
          state_d = FETCH;
        end else if (redirect) begin
          target_d = redirect_aligned;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_addr       = pc_q;
  assign instruction_out = fetch_valid ? imem_rdata : NOP_INSTR;
  assign pc_plus_4_out   = fetch_valid ? pc_inc : 32'd0;

  // A pending request must hold its address until acked.
  req_stable_a : assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, drives a req/ack instruction-memory port that tolerates wait states, and applies branch/jump redirects from ID. Presents each fetched instruction and its PC+4 to IF/ID, or a NOP bubble with PC+4 = 0 when no instruction is ready.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_write  in  1  hazard-unit enable. Low means stall, PC holds. Same signal as the IF/ID write_enable.
- redirect  in  1  taken branch/jump resolved in ID. Same signal as the IF/ID flush.
- redirect_target  in  32  new fetch address. Bits [1:0] are ignored and forced to 00.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  rdata valid this cycle. Memory may hold ack low for any number of wait states.
- imem_rdata  in  32  instruction word, qualified by imem_ack.
- instruction_out  out  32  to IF/ID instruction_in. Equals imem_rdata when fetch_valid, else 32'd0 (NOP).
- pc_plus_4_out  out  32  to IF/ID pc_plus_4_in. Equals pc+4 when fetch_valid, else 32'd0.
- fetch_valid  out  1  a real instruction is presented this cycle.

## Operation
Registers:
- pc (32).
- target_q (32).
- 2-bit state: BOOT, FETCH, DISCARD.

Memory protocol:
- Once imem_req rises, imem_req and imem_addr stay stable until the cycle in which imem_ack is high.
- Reads have no side effects. A held request may be acked repeatedly.

BOOT:
- imem_req = 0, outputs bubble.
- Always goes to FETCH on the next cycle.

FETCH:
- imem_req = 1, imem_addr = pc.
- redirect & imem_ack: pc <= redirect_target, stay FETCH, output bubble.
- redirect & ~imem_ack: target_q <= redirect_target, go to DISCARD, pc held.
- ~redirect & imem_ack & pc_write: fetch_valid = 1, pc <= pc+4.
- ~redirect & imem_ack & ~pc_write: fetch_valid = 1, pc held. IF/ID ignores the word and the same address is re-presented.
- ~imem_ack: bubble, pc held.

DISCARD:
- imem_req = 1, imem_addr = pc (the stale address, kept stable for the protocol). Outputs bubble.
- redirect & ~imem_ack: target_q <= redirect_target. The latest redirect wins.
- imem_ack: go to FETCH with pc <= (redirect ? redirect_target : target_q). The returned word is dropped.

Precedence and arithmetic:
- fetch_valid = (state == FETCH) & imem_ack & ~redirect.
- redirect has priority over pc_write. A redirect is honoured even while stalled.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
Reset values:
- pc = RESET_PC, target_q = 0, state = BOOT.
- imem_req = 0, imem_addr = RESET_PC.
- instruction_out = 0, pc_plus_4_out = 0, fetch_valid = 0.

Output paths:
- instruction_out, pc_plus_4_out and fetch_valid are combinational from state, pc, imem_ack, imem_rdata and redirect.
- The pipeline register is IF/ID. No additional register stage exists here.

Latency and throughput:
- First request is issued 1 cycle after reset deasserts.
- With zero wait states: ack in cycle N puts the word in IF/ID in cycle N+1.
- Sustained rate is 1 instruction/cycle.

Redirect latency:
- Redirect in FETCH with ack: the target is requested in the next cycle.
- Redirect during a wait state: the target is requested in the cycle after the stale ack.

Reset mid-operation:
- Asynchronous return to BOOT.
- Any outstanding memory access is abandoned. Memory must tolerate the req drop.

## Structure
Shared package (mips_pkg):
- fetch state enum {BOOT, FETCH, DISCARD}.
- NOP_INSTR = 32'd0.
- Default RESET_PC.

No sub-module. The PC incrementer and next-PC mux are inline.

## Test plan
- Reset release, memory always acks, pc_write = 1: addresses 0, 4, 8, … on consecutive cycles. IF/ID shows pc_plus_4 = 4, 8, 12 one cycle later.
- Two wait states per access: fetch_valid is high every third cycle. Bubbles are instruction_out = 0 and pc_plus_4_out = 0.
- pc_write low for 3 cycles with ack high: imem_addr holds 0x10 and instruction_out repeats the same word. After pc_write returns, the next address is 0x14.
- redirect to 0x0000_0102 with ack in the same cycle: that word is dropped and the next imem_addr is 0x100.
- redirect to 0x200 during a wait state, then redirect to 0x300 before the stale ack: imem_addr stays at the old pc until ack, with no fetch_valid. Next address is 0x300.
- pc = 32'hFFFF_FFFC acked: pc_plus_4_out = 0 and the next imem_addr is 0. Asserting rst mid-wait returns to BOOT with imem_req = 0.
